pipe_trace_buffer: RTL
======================

# pipe_trace_buffer

Synthesisable retire-trace buffer for the pipelined RISC-V core. It records one entry per WB-stage retirement (PC, instruction, destination, write-back data and optional hazard/forwarding flags) into a parametrised circular RAM. It supports free-running and PC-triggered capture with a programmable post-trigger window, and a readout port for board-level debug. It sits beside the pipeline CPU inside `sccomp`, fed from WB-stage signals, with readout driven by the switch/debug path.

## Interface
- `DEPTH`, 64: entries; power of two, ≥4.
- `XLEN`, 32: PC/instr/data width.
- `POST_W`, $clog2(DEPTH): width of post-trigger count.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: reset. Synchronous and active-high.
- `retire_valid` in 1: WB retirement this cycle.
- `retire_pc`, `retire_instr`, `retire_wdata` in XLEN each: retiring instruction's PC, encoding, write-back data.
- `retire_rd` in 5, `retire_we` in 1: destination register and RegWrite.
- `hz_stall`, `hz_flush_id`, `hz_flush_ex` in 1 each; `fwd_rs1`, `fwd_rs2` in 2 each: hazard/forwarding state, sampled with the retirement.
- `arm` in 1: pulse; clear the buffer and start capture.
- `stop` in 1: pulse; freeze immediately.
- `trig_en` in 1: enable PC trigger.
- `trig_pc` in XLEN: trigger PC.
- `post_len` in POST_W: entries to record after the trigger entry.
- `rd_req` in 1, `rd_idx` in $clog2(DEPTH): read request; index 0 is the oldest entry.
- `rd_valid` out 1, `rd_rec` out REC_W: read response.
- `state` out 2, `count` out $clog2(DEPTH)+1, `trig_idx` out $clog2(DEPTH), `triggered` out 1.
- `hz_events` out 16: saturating count of recorded entries with any hazard flag set.

## Operation
- Record layout, LSB first: wdata, instr, pc, rd(5), we(1), stall, flush_id, flush_ex, fwd_rs1(2), fwd_rs2(2). REC_W = 3·XLEN+13.
- States:
  - IDLE (0): nothing recorded.
  - CAPTURE (1): recording, awaiting trigger.
  - POST (2): recording, counting the post-trigger window.
  - FROZEN (3): no writes.
- Transitions:
  - IDLE/FROZEN→CAPTURE on `arm`. Clears `wr_ptr`, `count`, `triggered`, `hz_events`.
  - CAPTURE→POST on a recorded entry with `trig_en` && `retire_pc==trig_pc`. Latch `trig_idx` = that entry's index relative to the oldest entry after the write; set `triggered`; load `post_cnt`=`post_len`.
  - CAPTURE→FROZEN directly if the trigger fires with `post_len`=0.
  - POST: each recorded entry decrements `post_cnt`; the write that takes it to 0 → FROZEN.
  - Any state except IDLE →FROZEN on `stop`.
- Recording happens only in CAPTURE/POST with `retire_valid`=1. Write at `wr_ptr`, then `wr_ptr`+1 mod DEPTH. `count` saturates at DEPTH.
- Wrap-around: when full, the oldest entry is overwritten. The oldest index becomes `wr_ptr` (physical); `trig_idx` decrements with each overwrite and saturates at 0. An overwritten trigger entry is therefore reported as index 0.
- Read: physical address = (oldest + `rd_idx`) mod DEPTH. Reads with `rd_idx`≥`count` return an all-zero `rd_rec` with `rd_valid`=1.
- Priority in one cycle: `rst` > `arm` > `stop` > trigger > normal record. The entry presented with `arm` is recorded as entry 0 of the new capture. With `stop`, the same-cycle entry is not recorded.
- Reads are allowed in any state. During capture, the data returned reflects the state at the request edge.

## Timing
- Reset values: `state`=IDLE, `count`=0, `trig_idx`=0, `triggered`=0, `hz_events`=0, `rd_valid`=0, `rd_rec`=0.
- Write takes effect on the edge that samples `retire_valid`. The entry is readable by a `rd_req` in the next cycle.
- Read latency is 1 cycle: `rd_valid` is high for exactly the cycle after `rd_req`. Back-to-back requests are allowed, one per cycle.
- `state`, `count`, and `triggered` update on the same edge as the write that causes them.
- `rst` asserted mid-capture: all state clears at that edge; RAM contents become don't-care.

## Configuration
- `PIPE_TRACE_HAZARD_EN` defined: hazard fields are stored, and `hz_events` counts.
- Undefined: hazard inputs are ignored, the hazard bits of `rd_rec` read 0, and `hz_events` is held at 0. RAM width is unchanged.

## Structure
- `pipe_trace_pkg`: state enum, record field offsets, `REC_W` function of XLEN.
- Sub-module `pipe_trace_ram`: simple dual-port RAM, one write port, one synchronous read port, DEPTH×REC_W.

## Test plan
- Free-run, 10 retirements with PC 0x00–0x24, no trigger → `count`=10. `rd_idx` 0 returns pc 0x00; `rd_idx` 9 returns pc 0x24, 1 cycle after request.
- Wrap: DEPTH=8, 12 retirements with PC 4·k → `count`=8, `rd_idx` 0 returns pc 0x10, `rd_idx` 7 returns pc 0x2C.
- Trigger: `trig_pc`=0x40, `post_len`=3, PCs stepping by 4 from 0x30 → FROZEN after pc 0x4C. `trig_idx`=4, `triggered`=1.
- `arm` and a trigger-matching retirement in the same cycle → state CAPTURE→POST, `count`=1, `trig_idx`=0.
- `stop` mid-POST with a concurrent retirement → FROZEN; `count` unchanged.
- With the macro, 3 retirements carrying `hz_stall`=1 and 2 clean → `hz_events`=3. Without the macro → 0, and the hazard bits of `rd_rec` read 0.

Source files
------------

// File: rtl/pipe_trace_buffer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_trace_pkg
//  Description : Shared types and record layout for the retire-trace buffer.
//                Record fields, LSB first: wdata, instr, pc, rd, we, stall,
//                flush_id, flush_ex, fwd_rs1, fwd_rs2.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipe_trace_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_POST    = 2'd2,
        ST_FROZEN  = 2'd3
    } state_e;

    // Hazard/forwarding bits occupy the top of every record
    localparam int c_HZ_BITS = 7;

    function automatic int rec_w(input int xlen);
        return 3 * xlen + 13;
    endfunction

    function automatic int off_instr(input int xlen);
        return xlen;
    endfunction

    function automatic int off_pc(input int xlen);
        return 2 * xlen;
    endfunction

    function automatic int off_rd(input int xlen);
        return 3 * xlen;
    endfunction

    function automatic int off_we(input int xlen);
        return 3 * xlen + 5;
    endfunction

    function automatic int off_stall(input int xlen);
        return 3 * xlen + 6;
    endfunction

endpackage : pipe_trace_pkg
`default_nettype wire

// File: rtl/pipe_trace_buffer_if.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_trace_buffer_if
//  Description : Retirement feed, capture control and readout bundle for the
//                retire-trace buffer. master = pipeline/debug side,
//                slave = trace buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pipe_trace_buffer_if
    import pipe_trace_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int XLEN   = 32,
    parameter int POST_W = $clog2(DEPTH)
);
    localparam int c_AW    = $clog2(DEPTH);
    localparam int c_REC_W = rec_w(XLEN);

    logic               retire_valid;
    logic [XLEN-1:0]    retire_pc;
    logic [XLEN-1:0]    retire_instr;
    logic [XLEN-1:0]    retire_wdata;
    logic [4:0]         retire_rd;
    logic               retire_we;
    logic               hz_stall;
    logic               hz_flush_id;
    logic               hz_flush_ex;
    logic [1:0]         fwd_rs1;
    logic [1:0]         fwd_rs2;
    logic               arm;
    logic               stop;
    logic               trig_en;
    logic [XLEN-1:0]    trig_pc;
    logic [POST_W-1:0]  post_len;
    logic               rd_req;
    logic [c_AW-1:0]    rd_idx;
    logic               rd_valid;
    logic [c_REC_W-1:0] rd_rec;
    logic [1:0]         state;
    logic [c_AW:0]      count;
    logic [c_AW-1:0]    trig_idx;
    logic               triggered;
    logic [15:0]        hz_events;

    modport master (
        output retire_valid, retire_pc, retire_instr, retire_wdata,
               retire_rd, retire_we, hz_stall, hz_flush_id, hz_flush_ex,
               fwd_rs1, fwd_rs2, arm, stop, trig_en, trig_pc, post_len,
               rd_req, rd_idx,
        input  rd_valid, rd_rec, state, count, trig_idx, triggered, hz_events
    );

    modport slave (
        input  retire_valid, retire_pc, retire_instr, retire_wdata,
               retire_rd, retire_we, hz_stall, hz_flush_id, hz_flush_ex,
               fwd_rs1, fwd_rs2, arm, stop, trig_en, trig_pc, post_len,
               rd_req, rd_idx,
        output rd_valid, rd_rec, state, count, trig_idx, triggered, hz_events
    );

endinterface : pipe_trace_buffer_if
`default_nettype wire

// File: rtl/pipe_trace_buffer_ram.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_trace_ram
//  Description : Simple dual-port RAM, one write port and one synchronous
//                read port. A read and write to the same address on the same
//                edge returns the old contents.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_trace_ram #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 109
) (
    input  wire logic                     clk,
    input  wire logic                     i_we,
    input  wire logic [$clog2(DEPTH)-1:0] i_waddr,
    input  wire logic [WIDTH-1:0]         i_wdata,
    input  wire logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic      [WIDTH-1:0]         o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    // Write port
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Registered read port
    always_ff @(posedge clk) begin
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule : pipe_trace_ram
`default_nettype wire

// File: rtl/pipe_trace_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_trace_buffer
//  Description : Retire-trace buffer. Records one entry per WB retirement into
//                a circular RAM; free-running or PC-triggered capture with a
//                post-trigger window; 1-cycle readout by oldest-relative index.
//                Optional macro PIPE_TRACE_HAZARD_EN stores hazard/forwarding
//                bits and enables the hz_events counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_trace_buffer
    import pipe_trace_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int XLEN   = 32,
    parameter int POST_W = $clog2(DEPTH)
) (
    input  wire logic          clk,
    input  wire logic          rst,
    pipe_trace_buffer_if.slave if_bus
);

    localparam int            c_AW     = $clog2(DEPTH);
    localparam int            c_REC_W  = rec_w(XLEN);
    localparam int            c_OFF_HZ = off_stall(XLEN);
    localparam logic [c_AW:0] c_FULL   = (c_AW+1)'(DEPTH);

    state_e              r_state,     w_state_nx;
    logic [c_AW-1:0]     r_wr_ptr,    w_wr_ptr_nx;
    logic [c_AW:0]       r_count,     w_count_nx;
    logic [c_AW-1:0]     r_trig_idx,  w_trig_idx_nx;
    logic                r_triggered, w_triggered_nx;
    logic [POST_W-1:0]   r_post_cnt,  w_post_cnt_nx;
    logic [15:0]         r_hz_events, w_hz_events_nx;

    logic                w_rec;
    logic                w_trig_ok;
    logic [c_AW-1:0]     w_waddr;
    logic [c_AW:0]       w_base_count;
    logic                w_full_before;
    logic                w_trig_hit;
    logic [c_HZ_BITS-1:0] w_hz_bits;
    logic                w_hz_any;
    logic [c_REC_W-1:0]  w_wdata;

    logic [c_AW-1:0]     w_oldest;
    logic [c_AW-1:0]     w_raddr;
    logic [c_REC_W-1:0]  w_rdata;
    logic [c_REC_W-1:0]  w_rd_fields;
    logic                r_rd_valid;
    logic                r_rd_oob;

`ifdef PIPE_TRACE_HAZARD_EN
    assign w_hz_bits   = {if_bus.fwd_rs2, if_bus.fwd_rs1, if_bus.hz_flush_ex,
                          if_bus.hz_flush_id, if_bus.hz_stall};
    assign w_rd_fields = w_rdata;
`else
    // Hazard inputs are ignored; the RAM keeps its full width
    assign w_hz_bits   = '0;
    assign w_rd_fields = {{c_HZ_BITS{1'b0}}, w_rdata[c_OFF_HZ-1:0]};
`endif

    assign w_hz_any = |w_hz_bits;
    assign w_wdata  = {w_hz_bits, if_bus.retire_we, if_bus.retire_rd,
                       if_bus.retire_pc, if_bus.retire_instr, if_bus.retire_wdata};

    // Arm restarts the capture, so the occupancy seen by this cycle's write is 0
    assign w_base_count  = if_bus.arm ? '0 : r_count;
    assign w_full_before = (w_base_count == c_FULL);
    assign w_trig_hit    = w_rec && w_trig_ok && if_bus.trig_en &&
                           (if_bus.retire_pc == if_bus.trig_pc);

    // Next-state and capture bookkeeping; priority arm > stop > trigger > record
    always_comb begin
        w_state_nx     = r_state;
        w_wr_ptr_nx    = r_wr_ptr;
        w_count_nx     = r_count;
        w_trig_idx_nx  = r_trig_idx;
        w_triggered_nx = r_triggered;
        w_post_cnt_nx  = r_post_cnt;
        w_hz_events_nx = r_hz_events;
        w_rec          = 1'b0;
        w_trig_ok      = 1'b0;
        w_waddr        = r_wr_ptr;

        if (if_bus.arm) begin
            w_state_nx     = ST_CAPTURE;
            w_wr_ptr_nx    = '0;
            w_count_nx     = '0;
            w_trig_idx_nx  = '0;
            w_triggered_nx = 1'b0;
            w_post_cnt_nx  = '0;
            w_hz_events_nx = '0;
            w_waddr        = '0;
            w_rec          = if_bus.retire_valid;
            w_trig_ok      = 1'b1;
        end else if (if_bus.stop && (r_state != ST_IDLE)) begin
            w_state_nx = ST_FROZEN;
        end else begin
            w_rec     = if_bus.retire_valid &&
                        ((r_state == ST_CAPTURE) || (r_state == ST_POST));
            w_trig_ok = (r_state == ST_CAPTURE);
        end

        if (w_rec) begin
            w_wr_ptr_nx = w_waddr + 1'b1;
            if (!w_full_before) begin
                w_count_nx = w_base_count + 1'b1;
            end
            if (w_hz_any && (w_hz_events_nx != 16'hFFFF)) begin
                w_hz_events_nx = w_hz_events_nx + 16'd1;
            end

            if (w_trig_hit) begin
                w_triggered_nx = 1'b1;
                // When full, the new entry lands in the youngest slot
                w_trig_idx_nx  = w_full_before ? c_AW'(DEPTH - 1)
                                               : w_base_count[c_AW-1:0];
                w_post_cnt_nx  = if_bus.post_len;
                w_state_nx     = (if_bus.post_len == '0) ? ST_FROZEN : ST_POST;
            end else begin
                // Overwriting the oldest entry shifts the trigger one slot older
                if (w_full_before && (w_trig_idx_nx != '0)) begin
                    w_trig_idx_nx = w_trig_idx_nx - 1'b1;
                end
                if (w_state_nx == ST_POST) begin
                    w_post_cnt_nx = r_post_cnt - 1'b1;
                    if (r_post_cnt == POST_W'(1)) begin
                        w_state_nx = ST_FROZEN;
                    end
                end
            end
        end
    end

    // Capture state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_wr_ptr    <= '0;
            r_count     <= '0;
            r_trig_idx  <= '0;
            r_triggered <= 1'b0;
            r_post_cnt  <= '0;
            r_hz_events <= '0;
        end else begin
            r_state     <= w_state_nx;
            r_wr_ptr    <= w_wr_ptr_nx;
            r_count     <= w_count_nx;
            r_trig_idx  <= w_trig_idx_nx;
            r_triggered <= w_triggered_nx;
            r_post_cnt  <= w_post_cnt_nx;
            r_hz_events <= w_hz_events_nx;
        end
    end

    // Until the first wrap the oldest entry sits at physical slot 0
    assign w_oldest = (r_count == c_FULL) ? r_wr_ptr : '0;
    assign w_raddr  = w_oldest + if_bus.rd_idx;

    // Read response valid and out-of-range flag, aligned with the RAM output
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_valid <= 1'b0;
            r_rd_oob   <= 1'b0;
        end else begin
            r_rd_valid <= if_bus.rd_req;
            r_rd_oob   <= ({1'b0, if_bus.rd_idx} >= r_count);
        end
    end

    pipe_trace_ram #(
        .DEPTH (DEPTH),
        .WIDTH (c_REC_W)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_rec),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    assign if_bus.rd_valid  = r_rd_valid;
    assign if_bus.rd_rec    = (r_rd_valid && !r_rd_oob) ? w_rd_fields : '0;
    assign if_bus.state     = r_state;
    assign if_bus.count     = r_count;
    assign if_bus.trig_idx  = r_trig_idx;
    assign if_bus.triggered = r_triggered;
    assign if_bus.hz_events = r_hz_events;

endmodule : pipe_trace_buffer
`default_nettype wire
